// File: rtl/f_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: owns the PC, selects the next PC
// and flags fetch address errors before the instruction enters F/D.
module f_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_TOP    = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_PC_EN,
  input  logic        Req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_is_jump,
  input  logic        D_jump_taken,
  input  logic [31:0] D_jump_target,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_BD,
  output logic [4:0]  F_ExcCode
);

  logic [31:0] pc_q, pc_d;
  logic        adel;

  // Req is an asynchronous event from CP0 and must redirect even while stalled.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves pc_d unassigned (no latch).
    pc_d = pc_q;
    if (Req) begin
      pc_d = EXC_ENTRY;
    end else if (F_PC_EN) begin
      if (D_eret)            pc_d = EPC;
      else if (D_jump_taken) pc_d = D_jump_target;
      else                   pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_TOP);

  // While eret sits in D the current fetch is wrong-path: pass it on as a clean nop.
  always_comb begin
    i_inst_addr = pc_q;
    F_PC        = pc_q;
    F_instr     = i_inst_rdata;
    F_ExcCode   = 5'd0;
    F_BD        = D_is_jump && !D_eret;
    if (D_eret) begin
      F_instr   = 32'd0;
    end else if (adel) begin
      F_instr   = 32'd0;
      F_ExcCode = EXC_ADEL;
    end
  end

endmodule

// File: tb/tb_f_fetch_stage.sv
// Self-checking bench for f_fetch_stage: directed scenarios followed by random
// traffic, all compared against a PC model built from the next-PC rules.
module tb_f_fetch_stage;

  logic        clk;
  logic        reset;
  logic        F_PC_EN;
  logic        Req;
  logic        D_eret;
  logic [31:0] EPC;
  logic        D_is_jump;
  logic        D_jump_taken;
  logic [31:0] D_jump_target;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_BD;
  logic [4:0]  F_ExcCode;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_pc;

  f_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .F_PC_EN      (F_PC_EN),
    .Req          (Req),
    .D_eret       (D_eret),
    .EPC          (EPC),
    .D_is_jump    (D_is_jump),
    .D_jump_taken (D_jump_taken),
    .D_jump_target(D_jump_target),
    .i_inst_rdata (i_inst_rdata),
    .i_inst_addr  (i_inst_addr),
    .F_PC         (F_PC),
    .F_instr      (F_instr),
    .F_BD         (F_BD),
    .F_ExcCode    (F_ExcCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h (model_pc=%h)", tag, obs, exp, model_pc);
    end
  endtask

  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  // Reference next PC, straight from the priority list of redirect sources.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    if (reset)                  return 32'h0000_3000;
    if (Req)                    return 32'h0000_4180;
    if (F_PC_EN && D_eret)      return EPC;
    if (F_PC_EN && D_jump_taken) return D_jump_target;
    if (F_PC_EN)                return pc + 32'd4;
    return pc;
  endfunction

  task automatic check_outputs();
    logic        squash, fault;
    logic [31:0] exp_instr;
    logic [4:0]  exp_exc;
    squash    = D_eret;
    fault     = fetch_fault(model_pc);
    exp_instr = (squash || fault) ? 32'd0 : i_inst_rdata;
    exp_exc   = (!squash && fault) ? 5'd4 : 5'd0;
    check("F_PC",        F_PC,        model_pc);
    check("i_inst_addr", i_inst_addr, model_pc);
    check("F_instr",     F_instr,     exp_instr);
    check("F_ExcCode",   {27'd0, F_ExcCode}, {27'd0, exp_exc});
    check("F_BD",        {31'd0, F_BD}, {31'd0, D_is_jump && !D_eret});
  endtask

  // Inputs are already applied; check mid-cycle, then advance one clock.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_pc = next_pc(model_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic req, input logic eret, input logic [31:0] epc,
                       input logic isj, input logic jt, input logic [31:0] tgt);
    F_PC_EN       = en;
    Req           = req;
    D_eret        = eret;
    EPC           = epc;
    D_is_jump     = isj;
    D_jump_taken  = jt;
    D_jump_target = tgt;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [6];
    edges = '{32'h0000_2FFC, 32'h0000_3000, 32'h0000_6FFC, 32'h0000_7000, 32'hFFFF_FFFC, 32'h0000_3002};
    case ($urandom_range(0, 3))
      0:       return 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
      1:       return $urandom;
      2:       return edges[$urandom_range(0, 5)];
      default: return 32'h0000_3000 + $urandom_range(0, 32'h4000);
    endcase
  endfunction

  initial begin
    reset        = 1'b1;
    i_inst_rdata = 32'h2408_0001;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    model_pc = 32'h0000_3000;
    reset    = 1'b0;
    check("reset_pc", F_PC, 32'h0000_3000);

    // Sequential fetch.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (3) cycle();
    check("seq_pc", F_PC, 32'h0000_300C);
    cycle();
    check("pre_jump_pc", F_PC, 32'h0000_3010);

    // Taken jump, then the same jump while stalled.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_3100);
    cycle();
    check("jump_pc", F_PC, 32'h0000_3100);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_3010);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_3100);
    cycle();
    check("stall_jump_pc", F_PC, 32'h0000_3010);

    // Faulting targets: misaligned, above top, below base; plus a stalled fault.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_3102);
    cycle();
    check("adel_mis", {27'd0, F_ExcCode}, 32'd4);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    check("adel_stall_pc", F_PC, 32'h0000_3102);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_7000);
    cycle();
    check("adel_high", {27'd0, F_ExcCode}, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_2FFC);
    cycle();
    check("adel_low", {27'd0, F_ExcCode}, 32'd4);

    // Req while stalled, then Req together with eret.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_3020);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    check("req_stall_pc", F_PC, 32'h0000_4180);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'd0);
    cycle();
    check("req_eret_pc", F_PC, 32'h0000_4180);

    // eret squashes the fetch and its delay-slot flag.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3048, 1'b1, 1'b0, 32'd0);
    #1;
    check("eret_bd", {31'd0, F_BD}, 32'd0);
    check("eret_instr", F_instr, 32'd0);
    cycle();
    check("eret_pc", F_PC, 32'h0000_3048);

    // Reset during a stall dominates every redirect.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_3200);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    check("stall_3200", F_PC, 32'h0000_3200);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b1, 1'b1, 32'h0000_3300);
    cycle();
    reset = 1'b0;
    check("reset_dom_pc", F_PC, 32'h0000_3000);

    // Random traffic, including wrap-around and boundary addresses.
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      i_inst_rdata = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            pick_addr(), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, pick_addr());
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
